// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: legality check, store lane formatting,
// variable-latency memory handshake with timeout, and load-extraction hookup.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] split_original,
    output logic [2:0]  split_load_type,
    output logic [1:0]  split_addr_low,
    input  logic [31:0] split_result
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter value in the last ACCESS cycle allowed before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        legal;
    logic        timeout_hit;
    logic [7:0]  timeout_cnt;
    logic [2:0]  lat_type;
    logic        lat_store;
    logic [1:0]  lat_low;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign resp_data   = resp_valid ? split_result : 32'h0;

    // Reject unknown types, half/byte-unsigned stores, and misaligned halves/words.
    always_comb begin
        legal = 1'b1;
        if (req_type > 3'd4)
            legal = 1'b0;
        if (req_is_store && (req_type == 3'd1 || req_type == 3'd3))
            legal = 1'b0;
        if ((req_type == 3'd2 || req_type == 3'd3) && req_addr[0])
            legal = 1'b0;
        if (req_type == 3'd4 && req_addr[1:0] != 2'b00)
            legal = 1'b0;
    end

    // Place store data on the byte lanes it will occupy; loads read the whole word.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (req_is_store) begin
            case (req_type)
                3'd0: begin
                    be_next    = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
                3'd2: begin
                    be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = req_wdata;
                end
            endcase
        end
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and pipeline stall; ack takes priority over timeout.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && legal) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ack || timeout_hit)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered memory interface, status pulses, timeout counter and extraction inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= 32'h0;
            mem_be          <= 4'h0;
            mem_wdata       <= 32'h0;
            resp_valid      <= 1'b0;
            addr_exc        <= 1'b0;
            bus_err         <= 1'b0;
            timeout_cnt     <= 8'h0;
            lat_type        <= 3'h0;
            lat_store       <= 1'b0;
            lat_low         <= 2'h0;
            split_original  <= 32'h0;
            split_load_type <= 3'h0;
            split_addr_low  <= 2'h0;
        end else begin
            resp_valid <= 1'b0;
            addr_exc   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            addr_exc <= 1'b1;
                        end else begin
                            lat_type    <= req_type;
                            lat_store   <= req_is_store;
                            lat_low     <= req_addr[1:0];
                            mem_req     <= 1'b1;
                            mem_we      <= req_is_store;
                            mem_addr    <= {req_addr[31:2], 2'b00};
                            mem_be      <= be_next;
                            mem_wdata   <= wdata_next;
                            timeout_cnt <= 8'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!lat_store) begin
                            split_original  <= mem_rdata;
                            split_load_type <= lat_type;
                            split_addr_low  <= lat_low;
                            resp_valid      <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural load-extraction unit.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_is_store;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        addr_exc;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] split_original;
    logic [2:0]  split_load_type;
    logic [1:0]  split_addr_low;
    logic [31:0] split_result;

    int n_checks = 0;
    int n_fail   = 0;

    int          stall_cycles;
    int          req_cycles;
    int          resp_pulses;
    int          exc_pulses;
    int          berr_pulses;
    int          idle_data_bad;
    logic [31:0] last_resp;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [31:0] cap_orig;
    logic [2:0]  cap_type;
    logic [1:0]  cap_low;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_is_store    (req_is_store),
        .req_type        (req_type),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .stall           (stall),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .addr_exc        (addr_exc),
        .bus_err         (bus_err),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .split_original  (split_original),
        .split_load_type (split_load_type),
        .split_addr_low  (split_addr_low),
        .split_result    (split_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the existing load-extraction unit.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = split_original[8*split_addr_low +: 8];
        h = split_addr_low[1] ? split_original[31:16] : split_original[15:0];
        case (split_load_type)
            3'd0:    split_result = {{24{b[7]}}, b};
            3'd1:    split_result = {24'h0, b};
            3'd2:    split_result = {{16{h[15]}}, h};
            3'd3:    split_result = {16'h0, h};
            default: split_result = split_original;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one request for a single cycle, then watch a fixed window of cycles.
    // ack_delay = N acks in the Nth mem_req cycle; 0 never acks.
    task automatic applyStimulus(input logic is_store, input logic [2:0] typ, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ack_delay, input logic [31:0] rdata);
        stall_cycles  = 0;
        req_cycles    = 0;
        resp_pulses   = 0;
        exc_pulses    = 0;
        berr_pulses   = 0;
        idle_data_bad = 0;
        last_resp     = 32'h0;
        cap_we        = 1'b0;
        cap_addr      = 32'h0;
        cap_be        = 4'h0;
        cap_wdata     = 32'h0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = is_store;
        req_type     = typ;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
        if (stall) stall_cycles++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            if (addr_exc) exc_pulses++;
            if (bus_err) berr_pulses++;
            if (resp_valid) begin
                resp_pulses++;
                last_resp = resp_data;
                cap_orig  = split_original;
                cap_type  = split_load_type;
                cap_low   = split_addr_low;
            end else if (resp_data != 32'h0) begin
                idle_data_bad++;
            end
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_be    = mem_be;
                    cap_wdata = mem_wdata;
                end
                if (ack_delay != 0 && req_cycles == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int late_resp;
        int late_stall;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_type     = 3'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        cap_orig     = 32'h0;
        cap_type     = 3'h0;
        cap_low      = 2'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
        checkOutput("reset_stall", {31'h0, stall}, 32'h0);
        checkOutput("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("reset_split_orig", split_original, 32'h0);
        rst_n = 1'b1;

        // LB at 0x103, ack in second request cycle
        applyStimulus(1'b0, 3'd0, 32'h0000_0103, 32'h0, 2, 32'h80AA_55CC);
        checkOutput("lb_stall", stall_cycles, 3);
        checkOutput("lb_req_cycles", req_cycles, 2);
        checkOutput("lb_addr", cap_addr, 32'h0000_0100);
        checkOutput("lb_be", {28'h0, cap_be}, 32'hF);
        checkOutput("lb_we", {31'h0, cap_we}, 32'h0);
        checkOutput("lb_split_type", {29'h0, cap_type}, 32'h0);
        checkOutput("lb_split_low", {30'h0, cap_low}, 32'h3);
        checkOutput("lb_split_orig", cap_orig, 32'h80AA_55CC);
        checkOutput("lb_resp_pulses", resp_pulses, 1);
        checkOutput("lb_resp_data", last_resp, 32'hFFFF_FF80);
        checkOutput("lb_idle_data", idle_data_bad, 0);

        // SH at 0x22, fastest ack
        applyStimulus(1'b1, 3'd2, 32'h0000_0022, 32'h0000_BEEF, 1, 32'h0);
        checkOutput("sh_we", {31'h0, cap_we}, 32'h1);
        checkOutput("sh_addr", cap_addr, 32'h0000_0020);
        checkOutput("sh_be", {28'h0, cap_be}, 32'hC);
        checkOutput("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_resp_pulses", resp_pulses, 0);
        checkOutput("sh_stall", stall_cycles, 2);

        // LH at 0x02 (upper half, signed)
        applyStimulus(1'b0, 3'd2, 32'h0000_0002, 32'h0, 1, 32'h8001_1234);
        checkOutput("lh_resp_data", last_resp, 32'hFFFF_8001);
        checkOutput("lh_resp_pulses", resp_pulses, 1);

        // LBU at 0x101
        applyStimulus(1'b0, 3'd1, 32'h0000_0101, 32'h0, 3, 32'h80AA_55CC);
        checkOutput("lbu_resp_data", last_resp, 32'h0000_0055);
        checkOutput("lbu_stall", stall_cycles, 4);

        // Misaligned LW at 0x102
        applyStimulus(1'b0, 3'd4, 32'h0000_0102, 32'h0, 1, 32'h0);
        checkOutput("lw_mis_exc", exc_pulses, 1);
        checkOutput("lw_mis_req", req_cycles, 0);
        checkOutput("lw_mis_stall", stall_cycles, 0);

        // Store with req_type 3
        applyStimulus(1'b1, 3'd3, 32'h0000_0040, 32'h0, 1, 32'h0);
        checkOutput("st3_exc", exc_pulses, 1);
        checkOutput("st3_req", req_cycles, 0);

        // Unknown type 5
        applyStimulus(1'b0, 3'd5, 32'h0000_0040, 32'h0, 1, 32'h0);
        checkOutput("type5_exc", exc_pulses, 1);

        // Timeout: never ack
        applyStimulus(1'b0, 3'd4, 32'h0000_0200, 32'h0, 0, 32'h0);
        checkOutput("to_req_cycles", req_cycles, 4);
        checkOutput("to_bus_err", berr_pulses, 1);
        checkOutput("to_resp", resp_pulses, 0);
        checkOutput("to_stall", stall_cycles, 5);

        // Aligned LW right after, fastest ack
        applyStimulus(1'b0, 3'd4, 32'h0000_0200, 32'h0, 1, 32'h1234_5678);
        checkOutput("lw_resp_data", last_resp, 32'h1234_5678);
        checkOutput("lw_stall", stall_cycles, 2);

        // Reset during LHU access at 0x10
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_type     = 3'd3;
        req_addr     = 32'h0000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checkOutput("rst_pre_req", {31'h0, mem_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_req_drop", {31'h0, mem_req}, 32'h0);
        checkOutput("rst_stall_drop", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        late_resp  = 0;
        late_stall = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) late_resp++;
            if (stall) late_stall++;
        end
        checkOutput("rst_no_resp", late_resp, 0);
        checkOutput("rst_no_stall", late_stall, 0);

        // SB at 0x11 after reset
        applyStimulus(1'b1, 3'd0, 32'h0000_0011, 32'h1234_56A5, 1, 32'h0);
        checkOutput("sb_be", {28'h0, cap_be}, 32'h2);
        checkOutput("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_addr", cap_addr, 32'h0000_0010);
        checkOutput("sb_resp", resp_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage sequencer for data-memory loads and stores in the pipelined CPU.
- Checks alignment and builds byte enables and replicated store data.
- Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes.
- Drives the existing load-extraction unit (`split_word_load`): supplies the raw word, load type and low address bits, and returns the extracted result as the load response.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waiting for mem_ack before a bus error is flagged (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  MEM stage holds a load/store
- req_is_store  in  1  1 = store, 0 = load
- req_type  in  3  loads: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; stores: 0 SB, 2 SH, 4 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold IF..MEM stages
- resp_valid  out  1  one-cycle pulse, load data valid
- resp_data  out  32  extracted load data
- addr_exc  out  1  one-cycle pulse, misaligned or illegal request
- bus_err  out  1  one-cycle pulse, memory timeout
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, bits [1:0] forced to 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  memory completes request
- mem_rdata  in  32  read word, valid with mem_ack
- split_original  out  32  raw word to extraction unit
- split_load_type  out  3  load type to extraction unit
- split_addr_low  out  2  address bits [1:0] to extraction unit
- split_result  in  32  extraction result, combinational

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE.
  - All registered outputs 0, including mem_req, resp_valid, addr_exc, bus_err, split_*.
  - Timeout counter 0.
  - Asserting reset mid-access drops mem_req immediately; the access is abandoned with no response pulse.
- FSM states: IDLE, ACCESS, DONE.
- Legality check (combinational on request inputs):
  - Illegal if req_type > 4.
  - Illegal if req_is_store and req_type is 1 or 3.
  - Illegal if type LH/LHU/SH and addr[0] = 1.
  - Illegal if type LW/SW and addr[1:0] ≠ 00.
- IDLE with req_valid and an illegal request:
  - addr_exc = 1 next cycle for exactly one cycle; no memory request.
  - stall stays 0; remain IDLE.
- IDLE with req_valid and a legal request:
  - Latch type, is_store and addr[1:0].
  - Next cycle: mem_req = 1, mem_we = is_store, mem_addr = {addr[31:2],00}; go ACCESS.
- Store lane formatting:
  - SB: mem_be = 0001 << addr[1:0], mem_wdata = byte replicated ×4.
  - SH: mem_be = 1100 if addr[1] else 0011, mem_wdata = {half, half}.
  - SW: mem_be = 1111, mem_wdata = req_wdata.
- Loads: mem_be = 1111.
- stall (combinational) = (IDLE & req_valid & legal) | ACCESS. It is 0 in DONE, so the pipeline advances on the DONE-cycle edge.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata held stable until mem_ack.
  - Counter increments each cycle without mem_ack.
  - mem_ack for a load: split_original <= mem_rdata, split_load_type <= latched type, split_addr_low <= latched addr[1:0].
  - On mem_ack, mem_req drops next cycle; go DONE.
  - Counter reaching TIMEOUT_CYCLES without ack: drop mem_req, bus_err = 1 for the DONE cycle, go DONE.
  - mem_ack in the same cycle as the timeout: ack wins.
- DONE (one cycle):
  - Completed load: resp_valid = 1 and resp_data = split_result.
  - Store or timeout: resp_valid = 0.
  - Always return to IDLE.
- mem_ack outside ACCESS is ignored.
- Back-to-back requests: a new req_valid in the cycle after DONE starts immediately, so there is one IDLE cycle between accesses.
- Fastest access (ack in the first ACCESS cycle) is 3 cycles from request to DONE, with 2 stall cycles.
- split_* outputs hold their last load values outside loads. resp_data = 0 when resp_valid = 0.

Test Plan:
- LB at addr 0x103, mem_rdata 0x80AA55CC, ack after 2 cycles:
  - split_load_type = 0, split_addr_low = 11, split_original = 0x80AA55CC.
  - resp_data = 0xFFFFFF80 with resp_valid pulse.
  - stall high exactly 3 cycles.
- SH at addr 0x22, req_wdata 0x0000BEEF:
  - mem_we = 1, mem_addr = 0x20, mem_be = 1100, mem_wdata = 0xBEEFBEEF.
  - No resp_valid.
- LW at 0x102:
  - addr_exc pulse 1 cycle, mem_req never asserts, stall stays 0.
- Store with req_type = 3:
  - addr_exc pulse.
- TIMEOUT_CYCLES = 4, mem_ack held low:
  - mem_req high 4 cycles, bus_err pulse, resp_valid 0, FSM back to IDLE.
- rst_n pulled low during ACCESS of LHU at 0x10:
  - mem_req falls immediately.
  - After release, no resp_valid and state is IDLE.
  - A new SB at 0x11 issues mem_be = 0010.
